fib_sequencer: RTL and testbench
================================

// Module: fib_sequencer
// PURPOSE
//  Control stage that drives the 8-bit ripple adder to generate Fibonacci terms F0..F(N-1).
//  Holds the two most recent terms, presents them as adder operands, and captures sum/carry.
//  Streams each term downstream on a valid/ready interface.
//  Carry-out from the adder is the overflow detector.
// PARAMETERS
//  WIDTH  8  term/operand width; must equal adder width
//  CNT_W  8  width of num_terms and term_index
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      1-cycle request to begin a sequence; ignored while busy
//  num_terms   in   CNT_W  terms requested; sampled on accepted start
//  busy        out  1      high from accepted start until done pulse (inclusive)
//  add_a       out  WIDTH  adder operand a = current term register
//  add_b       out  WIDTH  adder operand b = next term register
//  add_cin     out  1      adder carry-in; constant 0
//  add_sum     in   WIDTH  adder sum (combinational return)
//  add_cout    in   1      adder carry-out (combinational return)
//  term_data   out  WIDTH  term value being offered
//  term_index  out  CNT_W  Fibonacci index of term_data (0-based)
//  term_valid  out  1      term_data/term_index valid
//  term_ready  in   1      downstream accepts when high with term_valid
//  done        out  1      1-cycle pulse at sequence end
//  overflow    out  1      sticky: a term exceeded WIDTH bits; cleared on next accepted start
// BEHAVIOUR
//  Reset: state IDLE; cur=0, nxt=0, index=0, cur_ovf=nxt_ovf=0. All outputs 0.
//  - term_valid, done, busy and overflow drop asynchronously on reset.
//  Reset mid-sequence aborts with no done pulse.
//  FSM IDLE -> EMIT -> ADD -> EMIT ... -> DONE -> IDLE.
//  IDLE: start=1 -> load cur=0, nxt=1, index=0, flags=0, overflow=0.
//  - If num_terms==0, go to DONE; otherwise go to EMIT.
//  EMIT: term_valid=1, term_data=cur, term_index=index.
//  - Data is held stable while valid & !ready.
//  - On valid & ready: if index==num_terms-1, go to DONE; otherwise go to ADD.
//  ADD (1 cycle, term_valid=0): cur<=nxt; nxt<=add_sum; index<=index+1.
//  - cur_ovf<=nxt_ovf; nxt_ovf<=nxt_ovf | add_cout.
//  - Then EMIT, unless the new cur_ovf=1 (see CONFIGURATION).
//  DONE: done=1 for exactly one cycle, then IDLE. busy=0 from the IDLE cycle.
//  Latency: accepted start at cycle k -> first term_valid at k+1.
//  - With ready held high, one term every 2 cycles.
//  Arithmetic: all sums go through the external adder only; add_cin=0.
//  - Registers are WIDTH bits (mod 2^WIDTH).
//  start while busy: ignored; num_terms is not resampled.
// CONFIGURATION
//  FIB_WRAP_EN undefined (default):
//  - An ADD producing cur_ovf=1 goes to DONE instead of EMIT and sets overflow=1.
//  - The overflowed term is never emitted, so fewer than num_terms terms may be sent.
//  FIB_WRAP_EN defined:
//  - Sequence continues for all num_terms terms.
//  - Wrapped values (mod 2^WIDTH) are emitted.
//  - overflow=1 is set when the first wrapped term is emitted.
// TESTING
//  1. Reset, start num_terms=5, ready=1 -> data 0,1,1,2,3 at index 0..4, done pulse, overflow=0.
//  2. num_terms=20, default build -> 14 terms (last is 233, idx 13), done pulse, overflow=1.
//  3. Same with FIB_WRAP_EN -> 20 terms; idx14=121, idx15=98, overflow=1 from idx14.
//  4. num_terms=4, ready toggles 0/1 each cycle -> no term lost or duplicated; data stable while stalled.
//  5. start with num_terms=0 -> no term_valid, done pulse next cycle.
//  6. Edge cases:
//     - start while busy -> ignored.
//     - rst_n low mid-EMIT -> term_valid/busy=0 immediately, no done pulse.
//     - New start after reset -> clean sequence from 0.

Source files
------------

// File: rtl/fib_sequencer.sv
// Fibonacci term generator driving an external WIDTH-bit adder, streaming terms on valid/ready.
// Define FIB_WRAP_EN to keep emitting wrapped terms instead of stopping at the first overflow.
module fib_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_terms,
   output logic             busy,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [WIDTH-1:0] term_data,
   output logic [CNT_W-1:0] term_index,
   output logic             term_valid,
   input  logic             term_ready,
   output logic             done,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] TERM_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cur_q, cur_d, nxt_q, nxt_d;
   logic [CNT_W-1:0] idx_q, idx_d, num_q, num_d;
   logic             cur_ovf_q, cur_ovf_d, nxt_ovf_q, nxt_ovf_d;
   logic             ovf_q, ovf_d, valid_q, valid_d, done_q, done_d, busy_q, busy_d;
   logic             last_term_s;

   assign last_term_s = (idx_q == (num_q - IDX_ONE));

   // Next-state, datapath and registered-output decode for the sequencer FSM.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      nxt_d     = nxt_q;
      idx_d     = idx_q;
      num_d     = num_q;
      cur_ovf_d = cur_ovf_q;
      nxt_ovf_d = nxt_ovf_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      busy_d    = busy_q;
      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            if (start) begin
               cur_d     = {WIDTH{1'b0}};
               nxt_d     = TERM_ONE;
               idx_d     = {CNT_W{1'b0}};
               num_d     = num_terms;
               cur_ovf_d = 1'b0;
               nxt_ovf_d = 1'b0;
               ovf_d     = 1'b0;
               busy_d    = 1'b1;
               if (num_terms == {CNT_W{1'b0}}) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_EMIT;
                  valid_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EMIT: begin
            if (term_ready) begin
               valid_d = 1'b0;
               if (last_term_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ADD;
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         S_ADD: begin
            cur_d     = nxt_q;
            nxt_d     = add_sum;
            idx_d     = idx_q + IDX_ONE;
            cur_ovf_d = nxt_ovf_q;
            nxt_ovf_d = nxt_ovf_q | add_cout;
`ifdef FIB_WRAP_EN
            state_d = S_EMIT;
            valid_d = 1'b1;
            ovf_d   = ovf_q | cur_ovf_d;
`else
            // The term about to become current never fit: stop before emitting it.
            if (cur_ovf_d) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               state_d = S_EMIT;
               valid_d = 1'b1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cur_q     <= {WIDTH{1'b0}};
         nxt_q     <= {WIDTH{1'b0}};
         idx_q     <= {CNT_W{1'b0}};
         num_q     <= {CNT_W{1'b0}};
         cur_ovf_q <= 1'b0;
         nxt_ovf_q <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         nxt_q     <= nxt_d;
         idx_q     <= idx_d;
         num_q     <= num_d;
         cur_ovf_q <= cur_ovf_d;
         nxt_ovf_q <= nxt_ovf_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign add_a      = cur_q;
   assign add_b      = nxt_q;
   assign add_cin    = 1'b0;
   assign term_data  = cur_q;
   assign term_index = idx_q;
   assign term_valid = valid_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Randomized self-checking bench for fib_sequencer; the bench also plays the external adder.
module tb_fib_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] num_terms;
   logic       busy;
   logic [7:0] add_a, add_b, add_sum;
   logic       add_cin, add_cout;
   logic [7:0] term_data;
   logic [7:0] term_index;
   logic       term_valid, term_ready, done, overflow;

   int checks = 0;
   int errors = 0;

`ifdef FIB_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   int got_d[$];
   int got_i[$];
   int got_o[$];
   int got_c[$];

   fib_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .busy(busy),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
      .term_data(term_data), .term_index(term_index), .term_valid(term_valid),
      .term_ready(term_ready), .done(done), .overflow(overflow)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

   always #5 clk = ~clk;

   // True (unbounded) Fibonacci value.
   function automatic longint fib(input int i);
      longint a = 0;
      longint b = 1;
      longint t;
      for (int k = 0; k < i; k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int exp_count(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) begin
         if (!WRAP && fib(i) > 255) break;
         c++;
      end
      return c;
   endfunction

   function automatic bit exp_final_ovf(input int n);
      bit o = 1'b0;
      for (int i = 0; i < n; i++) if (fib(i) > 255) o = 1'b1;
      return o;
   endfunction

   // Number of received terms disagreeing with the model (value, index, overflow flag).
   function automatic int term_errs();
      int bad = 0;
      for (int i = 0; i < got_d.size(); i++) begin
         if (got_i[i] != i || longint'(got_d[i]) != (fib(i) % 256) ||
             got_o[i] != int'(WRAP && fib(i) > 255)) bad++;
      end
      return bad;
   endfunction

   // Start a sequence and collect handshakes until done (bounded).
   task automatic run_seq(input int n, input int rmode, input int poke,
                          output int ndone, output bit first_valid, output bit first_ovf,
                          output int stall_err, output bit busy_ok, output bit busy_after);
      int  pd, pi;
      bit  have_prev;
      got_d.delete(); got_i.delete(); got_o.delete(); got_c.delete();
      ndone = 0; stall_err = 0; busy_ok = 1'b1; have_prev = 1'b0;
      first_valid = 1'b0; first_ovf = 1'b0; pd = 0; pi = 0;
      @(negedge clk);
      start = 1'b1;
      num_terms = n[7:0];
      for (int cyc = 0; cyc < 1000 && ndone == 0; cyc++) begin
         @(negedge clk);
         start = (poke != 0 && cyc == poke);
         if (start) num_terms = 8'd3;
         case (rmode)
            0:       term_ready = 1'b1;
            1:       term_ready = cyc[0];
            default: term_ready = 1'($urandom_range(0, 1));
         endcase
         if (cyc == 0) begin
            first_valid = term_valid;
            first_ovf   = overflow;
         end
         if (have_prev && (!term_valid || int'(term_data) != pd || int'(term_index) != pi))
            stall_err++;
         have_prev = term_valid && !term_ready;
         pd = int'(term_data);
         pi = int'(term_index);
         if (term_valid && term_ready) begin
            got_d.push_back(int'(term_data));
            got_i.push_back(int'(term_index));
            got_o.push_back(int'(overflow));
            got_c.push_back(cyc);
         end
         if (done) ndone++;
         if (!busy) busy_ok = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      term_ready = 1'b0;
      if (done) ndone++;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; num_terms = 8'd0; term_ready = 1'b0;
      #1;
      checks++;
      if ({busy, term_valid, done, overflow, term_data, term_index, add_a, add_b, add_cin} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b valid=%b done=%b ovf=%b data=%0d idx=%0d a=%0d b=%0d",
                  busy, term_valid, done, overflow, term_data, term_index, add_a, add_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int nd, se; bit fv, fo, bo, ba;
      run_seq(5, 0, 0, nd, fv, fo, se, bo, ba);
      checks++; if (got_d.size() !== 5) begin errors++; $display("FAIL basic_count: got %0d want 5", got_d.size()); end
      checks++; if (term_errs() !== 0) begin errors++; $display("FAIL basic_terms: %0d bad terms want 0", term_errs()); end
      checks++; if (fv !== 1'b1) begin errors++; $display("FAIL basic_latency: first valid %b want 1", fv); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done: %0d pulses want 1", nd); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", overflow); end
      checks++; if (bo !== 1'b1 || ba !== 1'b0) begin errors++; $display("FAIL basic_busy: during %b after %b want 1 0", bo, ba); end
      for (int i = 1; i < got_c.size(); i++) begin
         checks++;
         if (got_c[i] - got_c[i-1] !== 2) begin
            errors++; $display("FAIL basic_rate: term %0d gap %0d want 2", i, got_c[i] - got_c[i-1]);
         end
      end
   endtask

   task automatic test_overflow();
      int nd, se; bit fv, fo, bo, ba;
      run_seq(20, 0, 0, nd, fv, fo, se, bo, ba);
      checks++; if (got_d.size() !== exp_count(20)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_d.size(), exp_count(20)); end
      checks++; if (term_errs() !== 0) begin errors++; $display("FAIL ovf_terms: %0d bad terms want 0", term_errs()); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL ovf_done: %0d pulses want 1", nd); end
   endtask

   task automatic test_stall();
      int nd, se; bit fv, fo, bo, ba;
      run_seq(4, 1, 0, nd, fv, fo, se, bo, ba);
      checks++; if (got_d.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d want 4", got_d.size()); end
      checks++; if (term_errs() !== 0) begin errors++; $display("FAIL stall_terms: %0d bad terms want 0", term_errs()); end
      checks++; if (se !== 0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled want 0", se); end
   endtask

   task automatic test_zero();
      int nd, se; bit fv, fo, bo, ba;
      run_seq(0, 0, 0, nd, fv, fo, se, bo, ba);
      checks++; if (got_d.size() !== 0 || fv !== 1'b0) begin errors++; $display("FAIL zero_novalid: terms %0d first valid %b want 0 0", got_d.size(), fv); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL zero_done: %0d pulses want 1", nd); end
      checks++; if (fo !== 1'b0) begin errors++; $display("FAIL zero_ovf_clear: got %b want 0", fo); end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", ba); end
   endtask

   task automatic test_start_while_busy();
      int nd, se; bit fv, fo, bo, ba;
      run_seq(6, 2, 3, nd, fv, fo, se, bo, ba);
      checks++; if (got_d.size() !== 6) begin errors++; $display("FAIL busy_start_count: got %0d want 6", got_d.size()); end
      checks++; if (term_errs() !== 0) begin errors++; $display("FAIL busy_start_terms: %0d bad terms want 0", term_errs()); end
      checks++; if (nd !== 1 || se !== 0) begin errors++; $display("FAIL busy_start_done: pulses %0d stalls %0d want 1 0", nd, se); end
   endtask

   task automatic test_reset_mid();
      int nd, se; bit fv, fo, bo, ba;
      @(negedge clk);
      start = 1'b1; num_terms = 8'd10; term_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checks++; if (term_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: valid %b want 1", term_valid); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (term_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async: valid %b busy %b want 0 0", term_valid, busy); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone: done %b want 0", done); end
      end
      rst_n = 1'b1;
      run_seq(5, 0, 0, nd, fv, fo, se, bo, ba);
      checks++; if (got_d.size() !== 5 || term_errs() !== 0) begin errors++; $display("FAIL rst_mid_restart: terms %0d bad %0d want 5 0", got_d.size(), term_errs()); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL rst_mid_done: %0d pulses want 1", nd); end
   endtask

   task automatic test_random();
      int nd, se, n; bit fv, fo, bo, ba;
      for (int it = 0; it < 12; it++) begin
         n = $urandom_range(0, 30);
         run_seq(n, 2, 0, nd, fv, fo, se, bo, ba);
         checks++; if (got_d.size() !== exp_count(n)) begin errors++; $display("FAIL rand_count: n=%0d got %0d want %0d", n, got_d.size(), exp_count(n)); end
         checks++; if (term_errs() !== 0) begin errors++; $display("FAIL rand_terms: n=%0d %0d bad terms want 0", n, term_errs()); end
         checks++; if (nd !== 1 || se !== 0) begin errors++; $display("FAIL rand_done: n=%0d pulses %0d stalls %0d want 1 0", n, nd, se); end
         checks++; if (overflow !== exp_final_ovf(n)) begin errors++; $display("FAIL rand_ovf: n=%0d got %b want %b", n, overflow, exp_final_ovf(n)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_zero();
      test_stall();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
